// File: rtl/mem_load_unit.sv
// Load unit: accepts one RISC-V load, issues word-aligned reads to a variable-latency
// memory port (two reads for word-straddling accesses when enabled), returns the extended result.
module mem_load_unit #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned MISALIGN_SPLIT = 1,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_data,
    output logic              resp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              busy
);
    localparam int unsigned BYTES = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic [XLEN-1:0]   word0_q, word1_q;

    logic              legal_q;
    logic [3:0]        size;
    logic [OFF_W-1:0]  off_raw, off_eff;
    logic [4:0]        span;
    logic              split_need;
    logic [ADDR_W-1:0] addr_base, addr_next;
    logic [XLEN-1:0]   raw, mask, fill, ext;
    logic [6:0]        nbits;
    logic              sign_bit;

    // LD and LWU exist only on 64-bit datapaths
    function automatic logic f3_legal(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return 1'b1;
            3'b011, 3'b110:                         return XLEN == 64;
            default:                                return 1'b0;
        endcase
    endfunction

    assign legal_q    = f3_legal(funct3_q);
    assign size       = 4'd1 << funct3_q[1:0];
    assign off_raw    = addr_q[OFF_W-1:0];
    assign off_eff    = (MISALIGN_SPLIT != 0) ? off_raw : (off_raw & ~OFF_W'(size - 4'd1));
    assign span       = 5'(off_raw) + 5'(size);
    assign split_need = (MISALIGN_SPLIT != 0) && (span > 5'(BYTES));
    assign addr_base  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign addr_next  = addr_base + ADDR_W'(BYTES);

    // Extract size bytes at the offset, then fill above the access with the sign or zeros
    assign raw      = XLEN'({word1_q, word0_q} >> {off_eff, 3'b000});
    assign nbits    = {size, 3'b000};
    assign mask     = (XLEN'(1) << nbits) - XLEN'(1);
    assign sign_bit = |(raw & (mask ^ (mask >> 1)));
    assign fill     = (!funct3_q[2] && sign_bit) ? ~mask : '0;
    assign ext      = (raw & mask) | fill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid) state_d = f3_legal(req_funct3) ? S_REQ0 : S_RESP;
            S_REQ0:  if (mem_req_ready) state_d = S_WAIT0;
            S_WAIT0: if (mem_rvalid) state_d = split_need ? S_REQ1 : S_RESP;
            S_REQ1:  if (mem_req_ready) state_d = S_WAIT1;
            S_WAIT1: if (mem_rvalid) state_d = S_RESP;
            S_RESP:  if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch and read-word capture; words clear on accept so an unsplit word1 is 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            funct3_q <= '0;
            word0_q  <= '0;
            word1_q  <= '0;
        end else begin
            if (state_q == S_IDLE && req_valid) begin
                addr_q   <= req_addr;
                funct3_q <= req_funct3;
                word0_q  <= '0;
                word1_q  <= '0;
            end
            if (state_q == S_WAIT0 && mem_rvalid) word0_q <= mem_rdata;
            if (state_q == S_WAIT1 && mem_rvalid) word1_q <= mem_rdata;
        end
    end

    always_comb begin
        req_ready     = 1'b0;
        busy          = 1'b1;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        resp_valid    = 1'b0;
        resp_err      = 1'b0;
        resp_data     = '0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            S_REQ0: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = addr_base;
            end
            S_REQ1: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = addr_next;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = !legal_q;
                resp_data  = legal_q ? ext : '0;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_load_unit.sv
// Directed bench: three instances (32-bit split, 32-bit no-split, 64-bit split) see the same
// requests; each has its own zero-wait memory responder and response monitor.
module tb_mem_load_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_funct3 = '0;
    logic        resp_ready = 1'b1;
    logic        mem_rdy = 1'b1;
    logic        rv_en = 1'b1;
    logic        force_rv = 1'b0;
    logic [31:0] cur_d0 = '0, cur_d1 = '0;
    logic [63:0] cur_q0 = '0, cur_q1 = '0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int unsigned XW  = (k == 2) ? 64 : 32;
        localparam int unsigned SPL = (k == 1) ? 0 : 1;
        logic          req_ready, resp_valid, resp_err, mreq_valid, busy;
        logic          rvalid = 1'b0;
        logic [XW-1:0] resp_data;
        logic [XW-1:0] rdata = '0;
        logic [31:0]   mreq_addr;
        logic [63:0]   src0, src1;
        logic [63:0]   got_data = '0;
        logic          got_err = 1'b0;
        int            lat = 0, cnt = 0, nreq = 0, resp_n = 0, proto_err = 0;
        logic [31:0]   addr0 = '0, addr1 = '0, prev_addr = '0;
        logic          prev_stall = 1'b0, prev_hold = 1'b0;
        logic [XW-1:0] prev_data = '0;

        assign src0 = (k == 2) ? cur_q0 : 64'(cur_d0);
        assign src1 = (k == 2) ? cur_q1 : 64'(cur_d1);

        mem_load_unit #(.XLEN(XW), .MISALIGN_SPLIT(SPL), .ADDR_W(32)) u_dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid), .req_ready(req_ready),
            .req_addr(req_addr), .req_funct3(req_funct3),
            .resp_valid(resp_valid), .resp_ready(resp_ready),
            .resp_data(resp_data), .resp_err(resp_err),
            .mem_req_valid(mreq_valid), .mem_req_ready(mem_rdy),
            .mem_req_addr(mreq_addr),
            .mem_rvalid(rvalid | force_rv), .mem_rdata(rdata),
            .busy(busy)
        );

        // Memory responder, latency/response capture and handshake-stability monitor
        always @(posedge clk) begin
            rvalid <= 1'b0;
            if (rst) begin
                cnt        <= 0;
                prev_stall <= 1'b0;
                prev_hold  <= 1'b0;
            end else begin
                cnt <= cnt + 1;
                if (req_valid && req_ready) begin
                    cnt    <= 1;
                    nreq   <= 0;
                    resp_n <= 0;
                end
                if (mreq_valid && mem_rdy) begin
                    if (nreq == 0) addr0 <= mreq_addr;
                    else           addr1 <= mreq_addr;
                    nreq <= nreq + 1;
                    if (rv_en) begin
                        rvalid <= 1'b1;
                        rdata  <= XW'((nreq == 0) ? src0 : src1);
                    end
                end
                if (resp_valid && resp_ready) begin
                    got_data <= 64'(resp_data);
                    got_err  <= resp_err;
                    lat      <= cnt;
                    resp_n   <= resp_n + 1;
                end
                if (prev_stall && !(mreq_valid && mreq_addr == prev_addr)) proto_err <= proto_err + 1;
                if (prev_hold && !(resp_valid && resp_data == prev_data)) proto_err <= proto_err + 1;
                if (resp_valid && req_ready) proto_err <= proto_err + 1;
                prev_stall <= mreq_valid && !mem_rdy;
                prev_addr  <= mreq_addr;
                prev_hold  <= resp_valid && !resp_ready;
                prev_data  <= resp_data;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_res(input string tag, input int k, input logic [63:0] data,
                              input logic err, input int lat, input int nreq,
                              input logic [31:0] a0, input logic [31:0] a1);
        logic [63:0] g_data;
        logic        g_err;
        int          g_lat, g_nreq;
        logic [31:0] g_a0, g_a1;
        case (k)
            0: begin
                g_data = g_dut[0].got_data; g_err = g_dut[0].got_err; g_lat = g_dut[0].lat;
                g_nreq = g_dut[0].nreq; g_a0 = g_dut[0].addr0; g_a1 = g_dut[0].addr1;
            end
            1: begin
                g_data = g_dut[1].got_data; g_err = g_dut[1].got_err; g_lat = g_dut[1].lat;
                g_nreq = g_dut[1].nreq; g_a0 = g_dut[1].addr0; g_a1 = g_dut[1].addr1;
            end
            default: begin
                g_data = g_dut[2].got_data; g_err = g_dut[2].got_err; g_lat = g_dut[2].lat;
                g_nreq = g_dut[2].nreq; g_a0 = g_dut[2].addr0; g_a1 = g_dut[2].addr1;
            end
        endcase
        check($sformatf("%s.u%0d.data", tag, k), g_data, data);
        check($sformatf("%s.u%0d.err", tag, k), 64'(g_err), 64'(err));
        if (lat > 0) check($sformatf("%s.u%0d.lat", tag, k), 64'(g_lat), 64'(lat));
        check($sformatf("%s.u%0d.nreq", tag, k), 64'(g_nreq), 64'(nreq));
        if (nreq > 0) check($sformatf("%s.u%0d.addr0", tag, k), 64'(g_a0), 64'(a0));
        if (nreq > 1) check($sformatf("%s.u%0d.addr1", tag, k), 64'(g_a1), 64'(a1));
    endtask

    task automatic run_load(input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic [63:0] q0, input logic [63:0] q1,
                            input int mstall, input int rstall, input logic [63:0] hold_data);
        int t;
        @(negedge clk);
        cur_d0 = d0; cur_d1 = d1; cur_q0 = q0; cur_q1 = q1;
        mem_rdy    = (mstall == 0);
        resp_ready = (rstall == 0);
        req_addr   = addr;
        req_funct3 = f3;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < mstall; i++) begin
            @(negedge clk);
            check($sformatf("mstall%0d.valid", i), 64'(g_dut[0].mreq_valid), 64'd1);
            check($sformatf("mstall%0d.addr", i), 64'(g_dut[0].mreq_addr), 64'({addr[31:2], 2'b00}));
            @(posedge clk);
        end
        #1 mem_rdy = 1'b1;
        if (rstall > 0) begin
            t = 0;
            while (!g_dut[0].resp_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
            check("rstall.seen", 64'(g_dut[0].resp_valid), 64'd1);
            for (int i = 0; i < rstall; i++) begin
                check($sformatf("rstall%0d.data", i), 64'(g_dut[0].resp_data), hold_data);
                check($sformatf("rstall%0d.req_ready", i), 64'(g_dut[0].req_ready), 64'd0);
                @(negedge clk);
            end
            resp_ready = 1'b1;
        end
        t = 0;
        while (!(g_dut[0].resp_n > 0 && g_dut[1].resp_n > 0 && g_dut[2].resp_n > 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("done", 64'(g_dut[0].resp_n > 0 && g_dut[1].resp_n > 0 && g_dut[2].resp_n > 0), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst.req_ready", 64'(g_dut[0].req_ready), 64'd1);
        check("rst.busy", 64'(g_dut[0].busy), 64'd0);
        check("rst.resp_valid", 64'(g_dut[0].resp_valid), 64'd0);
        check("rst.mreq_valid", 64'(g_dut[0].mreq_valid), 64'd0);
        check("rst.resp_data", 64'(g_dut[0].resp_data), 64'd0);
        rst = 1'b0;

        // aligned LW
        run_load(32'h1000_0004, 3'b010, 32'hDEAD_BEEF, 32'h0, 64'hDEAD_BEEF_0000_0000, 64'h0, 0, 0, 64'h0);
        expect_res("lw", 0, 64'hDEAD_BEEF, 1'b0, 3, 1, 32'h1000_0004, 32'h0);
        expect_res("lw", 1, 64'hDEAD_BEEF, 1'b0, 3, 1, 32'h1000_0004, 32'h0);
        expect_res("lw", 2, 64'hFFFF_FFFF_DEAD_BEEF, 1'b0, 3, 1, 32'h1000_0000, 32'h0);
        // LB / LBU of byte 3
        run_load(32'h1000_0003, 3'b000, 32'h80FF_0011, 32'h0, 64'h0000_0000_80FF_0011, 64'h0, 0, 0, 64'h0);
        expect_res("lb", 0, 64'hFFFF_FF80, 1'b0, 3, 1, 32'h1000_0000, 32'h0);
        expect_res("lb", 1, 64'hFFFF_FF80, 1'b0, 3, 1, 32'h1000_0000, 32'h0);
        expect_res("lb", 2, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 3, 1, 32'h1000_0000, 32'h0);
        run_load(32'h1000_0003, 3'b100, 32'h80FF_0011, 32'h0, 64'h0000_0000_80FF_0011, 64'h0, 0, 0, 64'h0);
        expect_res("lbu", 0, 64'h80, 1'b0, 3, 1, 32'h1000_0000, 32'h0);
        expect_res("lbu", 1, 64'h80, 1'b0, 3, 1, 32'h1000_0000, 32'h0);
        expect_res("lbu", 2, 64'h80, 1'b0, 3, 1, 32'h1000_0000, 32'h0);
        // straddling LW
        run_load(32'h1000_0006, 3'b010, 32'h4433_2211, 32'h8877_6655,
                 64'h4433_2211_0000_0000, 64'h0000_0000_8877_6655, 0, 0, 64'h0);
        expect_res("lwx", 0, 64'h6655_4433, 1'b0, 5, 2, 32'h1000_0004, 32'h1000_0008);
        expect_res("lwx", 1, 64'h4433_2211, 1'b0, 3, 1, 32'h1000_0004, 32'h0);
        expect_res("lwx", 2, 64'h6655_4433, 1'b0, 5, 2, 32'h1000_0000, 32'h1000_0008);
        // funct3=011: illegal on 32-bit, LD on 64-bit
        run_load(32'h0000_0008, 3'b011, 32'h0, 32'h0, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 0, 64'h0);
        expect_res("ld", 0, 64'h0, 1'b1, 1, 0, 32'h0, 32'h0);
        expect_res("ld", 1, 64'h0, 1'b1, 1, 0, 32'h0, 32'h0);
        expect_res("ld", 2, 64'h0123_4567_89AB_CDEF, 1'b0, 3, 1, 32'h0000_0008, 32'h0);
        // funct3=111 illegal everywhere
        run_load(32'h1000_0000, 3'b111, 32'hFFFF_FFFF, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, 0, 64'h0);
        expect_res("ill", 0, 64'h0, 1'b1, 1, 0, 32'h0, 32'h0);
        expect_res("ill", 1, 64'h0, 1'b1, 1, 0, 32'h0, 32'h0);
        expect_res("ill", 2, 64'h0, 1'b1, 1, 0, 32'h0, 32'h0);
        // LHU at offset 3
        run_load(32'h1000_0003, 3'b101, 32'hAABB_CCDD, 32'h1122_3344, 64'h1122_3344_AABB_CCDD, 64'h0, 0, 0, 64'h0);
        expect_res("lhu", 0, 64'h44AA, 1'b0, 5, 2, 32'h1000_0000, 32'h1000_0004);
        expect_res("lhu", 1, 64'hAABB, 1'b0, 3, 1, 32'h1000_0000, 32'h0);
        expect_res("lhu", 2, 64'h44AA, 1'b0, 3, 1, 32'h1000_0000, 32'h0);
        // LH at the top of the address space wraps the second read to 0
        run_load(32'hFFFF_FFFF, 3'b001, 32'h3400_0000, 32'h0000_0092, 64'h3400_0000_0000_0000, 64'h92, 0, 0, 64'h0);
        expect_res("wrap", 0, 64'hFFFF_9234, 1'b0, 5, 2, 32'hFFFF_FFFC, 32'h0);
        expect_res("wrap", 1, 64'h3400, 1'b0, 3, 1, 32'hFFFF_FFFC, 32'h0);
        expect_res("wrap", 2, 64'hFFFF_FFFF_FFFF_9234, 1'b0, 5, 2, 32'hFFFF_FFF8, 32'h0);
        // LWU: illegal on 32-bit, zero-extended on 64-bit
        run_load(32'h1000_0004, 3'b110, 32'hDEAD_BEEF, 32'h0, 64'hDEAD_BEEF_0000_0000, 64'h0, 0, 0, 64'h0);
        expect_res("lwu", 0, 64'h0, 1'b1, 1, 0, 32'h0, 32'h0);
        expect_res("lwu", 2, 64'h0000_0000_DEAD_BEEF, 1'b0, 3, 1, 32'h1000_0000, 32'h0);
        // memory back-pressure for 4 cycles
        run_load(32'h1000_0004, 3'b010, 32'hDEAD_BEEF, 32'h0, 64'hDEAD_BEEF_0000_0000, 64'h0, 4, 0, 64'h0);
        expect_res("mbp", 0, 64'hDEAD_BEEF, 1'b0, 7, 1, 32'h1000_0004, 32'h0);
        expect_res("mbp", 2, 64'hFFFF_FFFF_DEAD_BEEF, 1'b0, 7, 1, 32'h1000_0000, 32'h0);
        // response back-pressure for 3 cycles
        run_load(32'h1000_0006, 3'b010, 32'h4433_2211, 32'h8877_6655,
                 64'h4433_2211_0000_0000, 64'h0000_0000_8877_6655, 0, 3, 64'h6655_4433);
        expect_res("rbp", 0, 64'h6655_4433, 1'b0, 0, 2, 32'h1000_0004, 32'h1000_0008);
        expect_res("rbp", 1, 64'h4433_2211, 1'b0, 0, 1, 32'h1000_0004, 32'h0);

        // reset while waiting for read data, then a stray rvalid
        rv_en = 1'b0;
        @(negedge clk);
        req_addr = 32'h1000_0004; req_funct3 = 3'b010; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int t = 0; t < 20 && g_dut[0].nreq < 1; t++) @(negedge clk);
        check("rstw.nreq", 64'(g_dut[0].nreq), 64'd1);
        check("rstw.busy", 64'(g_dut[0].busy), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstw.req_ready", 64'(g_dut[0].req_ready), 64'd1);
        check("rstw.busy0", 64'(g_dut[0].busy), 64'd0);
        check("rstw.mreq_valid", 64'(g_dut[0].mreq_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        force_rv = 1'b1;
        @(negedge clk);
        force_rv = 1'b0;
        repeat (4) @(negedge clk);
        check("rstw.resp_valid", 64'(g_dut[0].resp_valid), 64'd0);
        check("rstw.resp_n", 64'(g_dut[0].resp_n), 64'd0);
        check("rstw.idle", 64'(g_dut[0].busy), 64'd0);
        rv_en = 1'b1;
        run_load(32'h1000_0004, 3'b010, 32'h1357_9BDF, 32'h0, 64'h1357_9BDF_0000_0000, 64'h0, 0, 0, 64'h0);
        expect_res("post", 0, 64'h1357_9BDF, 1'b0, 3, 1, 32'h1000_0004, 32'h0);
        expect_res("post", 2, 64'h1357_9BDF, 1'b0, 3, 1, 32'h1000_0000, 32'h0);

        check("proto.u0", 64'(g_dut[0].proto_err), 64'd0);
        check("proto.u1", 64'(g_dut[1].proto_err), 64'd0);
        check("proto.u2", 64'(g_dut[2].proto_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
